// File: rtl/bram_ctrl_if.sv
// Handshake and strobe bundle between the line-buffer sequencer and its requesters.
// master: host/matrix side; slave: the bram_ctrl sequencer.
interface bram_ctrl_if #(
  parameter int OFF_W = 9
);
  logic             fill_req;
  logic             load_req;
  logic             host_wr_valid;
  logic             host_wr_ready;
  logic             chunk_valid;
  logic             chunk_ready;
  logic             load_ack;
  logic             host_rd_valid;
  logic             host_rd_ready;
  logic [OFF_W-1:0] bram_offset;
  logic             bram_line_wr;
  logic             bram_chunk_ld;
  logic             busy;

  modport master (
    output fill_req, load_req, host_wr_valid, chunk_ready, host_rd_ready,
    input  host_wr_ready, chunk_valid, load_ack, host_rd_valid,
           bram_offset, bram_line_wr, bram_chunk_ld, busy
  );

  modport slave (
    input  fill_req, load_req, host_wr_valid, chunk_ready, host_rd_ready,
    output host_wr_ready, chunk_valid, load_ack, host_rd_valid,
           bram_offset, bram_line_wr, bram_chunk_ld, busy
  );
endinterface

// File: rtl/bram_ctrl.sv
// Sequencer for the line buffer: arbitrates host fill vs. matrix load, walks the byte offset.
// Define BRAM_CTRL_RR_EN for round-robin arbitration; default is fixed priority (FILL first).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | idx held at 0, waiting for fill_req / load_req
// S_FILL  | accepting host bytes, one per host_wr_valid
// S_FULL  | complete line presented on chunk_out until chunk_ready
// S_LOAD  | single cycle: buffer captures chunk_input, load_ack pulses
// S_DRAIN | presenting buffered bytes to the host, one per host_rd_ready
module bram_ctrl #(
  parameter int NUM_BITS = 512,
  parameter int OFF_W    = 9
) (
  input logic        clk,
  input logic        rst,
  bram_ctrl_if.slave bus
);
  localparam int IDX_W = OFF_W - 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BITS / 8 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FULL,
    S_LOAD,
    S_DRAIN
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, idx_nx;

`ifdef BRAM_CTRL_RR_EN
  // 1 = most recent grant went to LOAD
  logic last_grant, last_grant_nx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
`ifdef BRAM_CTRL_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
`ifdef BRAM_CTRL_RR_EN
      last_grant <= last_grant_nx;
`endif
    end
  end

  always_comb begin
    state_nx          = state;
    idx_nx            = idx;
    bus.host_wr_ready = 1'b0;
    bus.chunk_valid   = 1'b0;
    bus.load_ack      = 1'b0;
    bus.host_rd_valid = 1'b0;
    bus.bram_line_wr  = 1'b0;
    bus.bram_chunk_ld = 1'b0;
`ifdef BRAM_CTRL_RR_EN
    last_grant_nx = last_grant;
`endif
    case (state)
      S_IDLE: begin
        idx_nx = '0;
`ifdef BRAM_CTRL_RR_EN
        if (bus.fill_req && (!bus.load_req || last_grant)) begin
          state_nx      = S_FILL;
          last_grant_nx = 1'b0;
        end else if (bus.load_req) begin
          state_nx      = S_LOAD;
          last_grant_nx = 1'b1;
        end
`else
        if (bus.fill_req) begin
          state_nx = S_FILL;
        end else if (bus.load_req) begin
          state_nx = S_LOAD;
        end
`endif
      end
      S_FILL: begin
        bus.host_wr_ready = 1'b1;
        bus.bram_line_wr  = bus.host_wr_valid;
        if (bus.host_wr_valid) begin
          if (idx == LAST_IDX) begin
            idx_nx   = '0;
            state_nx = S_FULL;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      S_FULL: begin
        bus.chunk_valid = 1'b1;
        if (bus.chunk_ready) state_nx = S_IDLE;
      end
      S_LOAD: begin
        bus.bram_chunk_ld = 1'b1;
        bus.load_ack      = 1'b1;
        state_nx          = S_DRAIN;
      end
      S_DRAIN: begin
        bus.host_rd_valid = 1'b1;
        if (bus.host_rd_ready) begin
          if (idx == LAST_IDX) begin
            idx_nx   = '0;
            state_nx = S_IDLE;
          end else begin
            idx_nx = idx + 1'b1;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus.bram_offset = {idx, 3'b111};
  assign bus.busy        = (state != S_IDLE);
endmodule
